// File: rtl/servo_cmd_scheduler.sv
// Servo command scheduler: parses A5/CMD/VAL/SUM packets, slews per-channel positions once per frame.
// Build macro SERVO_INVERT_EN: position commits store 255 - VAL for mirrored mounts.
module servo_cmd_scheduler #(
  parameter int         NUM_CH         = 2,
  parameter int         FRAME_CYCLES   = 1000000,
  parameter int         BYTE_TIMEOUT   = 52080,
  parameter int         TIMEOUT_FRAMES = 50,
  parameter logic [7:0] CENTER         = 8'd128
) (
  input  logic                clk50mhz,
  input  logic                rst,
  input  logic                rx_valid,
  input  logic [7:0]          rx_byte,
  output logic                frame_tick,
  output logic [8*NUM_CH-1:0] pos_flat,
  output logic                link_ok,
  output logic                pkt_err
);
  localparam int FW = $clog2(FRAME_CYCLES + 1);
  localparam int GW = $clog2(BYTE_TIMEOUT + 1);
  localparam int SW = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [7:0] HDR = 8'hA5;

  typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_CMD, GOT_VAL} parse_state_t;

  parse_state_t  state_reg, state_next;
  logic [FW-1:0] frame_cnt_reg;
  logic          frame_tick_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic [SW-1:0] silence_reg;
  logic          link_ok_reg;
  logic          pkt_err_reg;
  logic [7:0]    cmd_reg;
  logic [7:0]    val_reg;
  logic [7:0]    sum_calc;
  logic [7:0]    val_eff;
  logic          cmd_ch_ok;
  logic          byte_timeout;
  logic          bad_pkt;
  logic          commit_pos;
  logic          commit_step;
  logic          commit;
  logic          fail_entry;

  // Tick is registered off the last count so it lands in the cycle the counter reads 0,
  // and the first pulse comes a full frame after reset release.
  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      frame_cnt_reg  <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= (frame_cnt_reg == FW'(FRAME_CYCLES - 1));
      if (frame_cnt_reg == FW'(FRAME_CYCLES - 1))
        frame_cnt_reg <= '0;
      else
        frame_cnt_reg <= frame_cnt_reg + FW'(1);
    end
  end

  assign sum_calc  = cmd_reg + val_reg;
  assign cmd_ch_ok = ({1'b0, cmd_reg[6:0]} < 8'(NUM_CH));

`ifdef SERVO_INVERT_EN
  assign val_eff = 8'hFF - val_reg;
`else
  assign val_eff = val_reg;
`endif

  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      state_reg   <= IDLE;
      gap_cnt_reg <= '0;
      cmd_reg     <= '0;
      val_reg     <= '0;
      pkt_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pkt_err_reg <= bad_pkt | byte_timeout;
      if (rx_valid || state_reg == IDLE)
        gap_cnt_reg <= '0;
      else
        gap_cnt_reg <= gap_cnt_reg + GW'(1);
      if (rx_valid && state_reg == GOT_HDR)
        cmd_reg <= rx_byte;
      if (rx_valid && state_reg == GOT_CMD)
        val_reg <= rx_byte;
    end
  end

  always_comb begin
    state_next   = state_reg;
    byte_timeout = 1'b0;
    bad_pkt      = 1'b0;
    commit_pos   = 1'b0;
    commit_step  = 1'b0;
    if (state_reg != IDLE && !rx_valid && gap_cnt_reg == GW'(BYTE_TIMEOUT - 1)) begin
      byte_timeout = 1'b1;
      state_next   = IDLE;
    end else if (rx_valid) begin
      case (state_reg)
        IDLE:    if (rx_byte == HDR) state_next = GOT_HDR;
        GOT_HDR: state_next = GOT_CMD;
        GOT_CMD: state_next = GOT_VAL;
        GOT_VAL: begin
          state_next = IDLE;
          if (rx_byte != sum_calc)
            bad_pkt = 1'b1;
          else if (!cmd_reg[7] && cmd_ch_ok)
            commit_pos = 1'b1;
          else if (cmd_reg[7] && cmd_ch_ok)
            commit_step = 1'b1;
          else
            bad_pkt = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign commit = commit_pos | commit_step;
  // A commit landing on the failsafe frame keeps the link alive and suppresses the recentre.
  assign fail_entry = frame_tick_reg && !commit &&
                      (silence_reg == SW'(TIMEOUT_FRAMES - 1));

  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      silence_reg <= '0;
      link_ok_reg <= 1'b0;
    end else begin
      if (commit)
        silence_reg <= '0;
      else if (frame_tick_reg && silence_reg != SW'(TIMEOUT_FRAMES))
        silence_reg <= silence_reg + SW'(1);
      if (commit)
        link_ok_reg <= 1'b1;
      else if (fail_entry)
        link_ok_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [7:0]        pos_reg;
      logic [7:0]        target_reg;
      logic [3:0]        step_reg;
      logic signed [8:0] diff;
      logic [7:0]        mag;
      logic [7:0]        move;
      logic              ch_hit;

      assign ch_hit = (cmd_reg[6:0] == 7'(gi));

      always_comb begin
        diff = $signed({1'b0, target_reg}) - $signed({1'b0, pos_reg});
        mag  = diff[8] ? 8'(-diff) : 8'(diff);
        move = (mag < {4'b0, step_reg}) ? mag : {4'b0, step_reg};
      end

      // Slew reads the pre-edge target/step, so a same-cycle commit takes effect next frame.
      always_ff @(posedge clk50mhz) begin
        if (rst) begin
          pos_reg    <= CENTER;
          target_reg <= CENTER;
          step_reg   <= 4'd1;
        end else begin
          if (frame_tick_reg)
            pos_reg <= diff[8] ? (pos_reg - move) : (pos_reg + move);
          if (commit_pos && ch_hit)
            target_reg <= val_eff;
          else if (fail_entry)
            target_reg <= CENTER;
          if (commit_step && ch_hit)
            step_reg <= (val_reg[3:0] == 4'd0) ? 4'd1 : val_reg[3:0];
        end
      end

      assign pos_flat[8*gi +: 8] = pos_reg;
    end
  endgenerate

  assign frame_tick = frame_tick_reg;
  assign link_ok    = link_ok_reg;
  assign pkt_err    = pkt_err_reg;

endmodule
